mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous data/instruction BRAM between the control unit's two requesters:

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_arb_perf.sv | 35 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encodings, requester IDs and counter helpers for mem_port_arbiter.
// Used by the arbiter top and by the optional performance-counter block.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

   localparam int PERF_W = 32;

   // Saturating increment: parks at all-ones instead of wrapping.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (IF/DM) and memory-macro signals of the arbiter.
// slave = arbiter side, master = requesters plus memory macro side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: saturating IF-done, DM-done and IDLE-conflict event counters.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_if_done,
   input  logic              i_dm_done,
   input  logic              i_conflict,
   output logic [PERF_W-1:0] o_if_cnt,
   output logic [PERF_W-1:0] o_dm_cnt,
   output logic [PERF_W-1:0] o_conflict_cnt
);
   logic [2:0] w_evt;

   assign w_evt = {i_conflict, i_dm_done, i_if_done};

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [PERF_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_evt[gi]) begin
            r_cnt <= sat_inc(r_cnt);
         end
      end
   end

   assign o_if_cnt       = g_cnt[0].r_cnt;
   assign o_dm_cnt       = g_cnt[1].r_cnt;
   assign o_conflict_cnt = g_cnt[2].r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port BRAM between instruction fetch and data load/store, DM first.
// Define MEM_ARB_PERF_EN to add saturating perf_if_cnt / perf_dm_cnt / perf_conflict_cnt outputs.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave io_bus,
   output logic              busy
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_if_cnt,
   output logic [PERF_W-1:0] perf_dm_cnt,
   output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);
   localparam int               LAT_W    = $clog2(READ_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

   state_t            r_state;
   state_t            w_state_next;
   gnt_t              r_gnt;
   logic [LAT_W-1:0]  r_lat_cnt;

   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   logic              w_grant;
   logic              w_grant_dm;
   logic              w_store;
   logic              w_lat_done;
   logic              w_if_done;
   logic              w_dm_done;

   // A grant is only ever taken from IDLE, so RESP always returns through one IDLE cycle.
   assign w_grant    = (r_state == ST_IDLE) && (io_bus.dm_req || io_bus.if_req);
   assign w_grant_dm = io_bus.dm_req;
   assign w_store    = w_grant && w_grant_dm && io_bus.dm_we;
   assign w_lat_done = (r_lat_cnt == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; r_mem_we is high in ACCESS exactly when the access is a store.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_grant) w_state_next = ST_ACCESS;
         ST_ACCESS: w_state_next = r_mem_we ? ST_RESP : ST_WAIT;
         ST_WAIT:   if (w_lat_done) w_state_next = ST_RESP;
         ST_RESP:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (r_state != ST_IDLE);
      w_if_done = (r_state == ST_RESP) && (r_gnt == GNT_IF);
      w_dm_done = (r_state == ST_RESP) && (r_gnt == GNT_DM);
   end

   // Memory command registers double as the latched request; they are non-zero only in ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_gnt       <= GNT_IF;
      end else begin
         r_mem_en    <= w_grant;
         r_mem_we    <= w_store;
         r_mem_wdata <= w_store ? io_bus.dm_wdata : '0;
         if (!w_grant) begin
            r_mem_addr <= '0;
         end else begin
            r_mem_addr <= w_grant_dm ? io_bus.dm_addr : io_bus.if_addr;
         end
         if (w_grant) begin
            r_gnt <= w_grant_dm ? GNT_DM : GNT_IF;
         end
      end
   end

   // Read-latency countdown and return-data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lat_cnt  <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         if (r_state == ST_ACCESS) begin
            r_lat_cnt <= LAT_INIT;
         end else if ((r_state == ST_WAIT) && !w_lat_done) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
         end
         if ((r_state == ST_WAIT) && w_lat_done) begin
            if (r_gnt == GNT_DM) begin
               r_dm_rdata <= io_bus.mem_rdata;
            end else begin
               r_if_rdata <= io_bus.mem_rdata;
            end
         end
      end
   end

   assign io_bus.mem_en    = r_mem_en;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_wdata = r_mem_wdata;
   assign io_bus.if_done   = w_if_done;
   assign io_bus.dm_done   = w_dm_done;
   assign io_bus.if_rdata  = r_if_rdata;
   assign io_bus.dm_rdata  = r_dm_rdata;

`ifdef MEM_ARB_PERF_EN
   logic w_conflict;

   assign w_conflict = (r_state == ST_IDLE) && io_bus.dm_req && io_bus.if_req;

   mem_arb_perf u_perf (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_if_done      (w_if_done),
      .i_dm_done      (w_dm_done),
      .i_conflict     (w_conflict),
      .o_if_cnt       (perf_if_cnt),
      .o_dm_cnt       (perf_dm_cnt),
      .o_conflict_cnt (perf_conflict_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (READ_LATENCY 1 and 4) against a cycle-arithmetic model plus directed vectors.
// Honours MEM_ARB_PERF_EN so the perf counters are checked when the feature is built in.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int NI     = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NI-1:0]             if_req, dm_req, dm_we;
   logic [NI-1:0][ADDR_W-1:0] if_addr, dm_addr;
   logic [NI-1:0][DATA_W-1:0] dm_wdata;
   wire  [NI-1:0]             if_done, dm_done, mem_en, mem_we, busy;
   wire  [NI-1:0][ADDR_W-1:0] mem_addr;
   wire  [NI-1:0][DATA_W-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
   wire  [NI-1:0][31:0]       perf_if_cnt, perf_dm_cnt, perf_cf_cnt;
`endif

   // Memory macro stand-in: write-through array plus a 4-deep read pipeline.
   logic [DATA_W-1:0] env_mem [NI][DEPTH];
   bit                env_wr  [NI][DEPTH];
   bit   [DATA_W-1:0] pipe    [NI][4];

   function automatic int rl_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      return 32'h2002_0000 + {24'd0, a[9:2]} + {18'd0, a[1:0], 12'd0};
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus ();

      assign u_bus.if_req    = if_req[gi];
      assign u_bus.if_addr   = if_addr[gi];
      assign u_bus.dm_req    = dm_req[gi];
      assign u_bus.dm_we     = dm_we[gi];
      assign u_bus.dm_addr   = dm_addr[gi];
      assign u_bus.dm_wdata  = dm_wdata[gi];
      assign u_bus.mem_rdata = mem_rdata[gi];
      assign if_done[gi]     = u_bus.if_done;
      assign if_rdata[gi]    = u_bus.if_rdata;
      assign dm_done[gi]     = u_bus.dm_done;
      assign dm_rdata[gi]    = u_bus.dm_rdata;
      assign mem_en[gi]      = u_bus.mem_en;
      assign mem_we[gi]      = u_bus.mem_we;
      assign mem_addr[gi]    = u_bus.mem_addr;
      assign mem_wdata[gi]   = u_bus.mem_wdata;
      assign mem_rdata[gi]   = pipe[gi][rl_of(gi) - 1];

      mem_port_arbiter #(
         .ADDR_W       (ADDR_W),
         .DATA_W       (DATA_W),
         .READ_LATENCY ((gi == 0) ? 1 : 4)
      ) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .io_bus (u_bus),
         .busy   (busy[gi])
`ifdef MEM_ARB_PERF_EN
         ,
         .perf_if_cnt       (perf_if_cnt[gi]),
         .perf_dm_cnt       (perf_dm_cnt[gi]),
         .perf_conflict_cnt (perf_cf_cnt[gi])
`endif
      );
   end

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
         pipe[k][0] <= '0;
         if (mem_en[k]) begin
            if (mem_we[k]) begin
               env_mem[k][mem_addr[k]] <= mem_wdata[k];
               env_wr[k][mem_addr[k]]  <= 1'b1;
            end else begin
               pipe[k][0] <= env_wr[k][mem_addr[k]] ? env_mem[k][mem_addr[k]] : init_word(mem_addr[k]);
            end
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[dut%0d] cyc %0d: got 0x%0h, want 0x%0h", name, k, cyc, act, exp);
      end
   endtask

   // Model: each access is a grant cycle g; mem_en at g+1, done at g+2 (store) or g+2+RL, free again after done.
   logic [DATA_W-1:0] sh_mem [NI][DEPTH];
   bit                sh_wr  [NI][DEPTH];
   bit                m_act [NI];
   bit                m_dm  [NI];
   bit                m_we  [NI];
   int                m_g   [NI];
   logic [ADDR_W-1:0] m_addr  [NI];
   logic [DATA_W-1:0] m_wdata [NI];
   logic [DATA_W-1:0] m_ifr   [NI];
   logic [DATA_W-1:0] m_dmr   [NI];
   int                m_ifc [NI];
   int                m_dmc [NI];
   int                m_cfc [NI];

   function automatic logic [DATA_W-1:0] sh_read(input int k, input logic [ADDR_W-1:0] a);
      return sh_wr[k][a] ? sh_mem[k][a] : init_word(a);
   endfunction

   task automatic compare_cycle();
      cyc++;
      for (int k = 0; k < NI; k++) begin
         bit store;
         bit in_acc;
         bit at_done;
         int d;
         if (!rst_n) begin
            m_act[k] = 1'b0;
            m_ifr[k] = '0;
            m_dmr[k] = '0;
            m_ifc[k] = 0;
            m_dmc[k] = 0;
            m_cfc[k] = 0;
         end
         store   = m_dm[k] && m_we[k];
         d       = m_g[k] + 2 + (store ? 0 : rl_of(k));
         in_acc  = m_act[k] && (cyc == m_g[k] + 1);
         at_done = m_act[k] && (cyc == d);
         if (at_done && !store) begin
            if (m_dm[k]) m_dmr[k] = sh_read(k, m_addr[k]);
            else         m_ifr[k] = sh_read(k, m_addr[k]);
         end
         chk("busy", k, 64'(busy[k]), 64'(m_act[k] && (cyc > m_g[k]) && (cyc <= d)));
         chk("mem_en", k, 64'(mem_en[k]), 64'(in_acc));
         chk("mem_we", k, 64'(mem_we[k]), 64'(in_acc && store));
         chk("mem_addr", k, 64'(mem_addr[k]), in_acc ? 64'(m_addr[k]) : 64'd0);
         if (!in_acc)    chk("mem_wdata_idle", k, 64'(mem_wdata[k]), 64'd0);
         else if (store) chk("mem_wdata", k, 64'(mem_wdata[k]), 64'(m_wdata[k]));
         chk("if_done", k, 64'(if_done[k]), 64'(at_done && !m_dm[k]));
         chk("dm_done", k, 64'(dm_done[k]), 64'(at_done && m_dm[k]));
         chk("if_rdata", k, 64'(if_rdata[k]), 64'(m_ifr[k]));
         chk("dm_rdata", k, 64'(dm_rdata[k]), 64'(m_dmr[k]));
`ifdef MEM_ARB_PERF_EN
         chk("perf_if", k, 64'(perf_if_cnt[k]), 64'(m_ifc[k]));
         chk("perf_dm", k, 64'(perf_dm_cnt[k]), 64'(m_dmc[k]));
         chk("perf_cf", k, 64'(perf_cf_cnt[k]), 64'(m_cfc[k]));
`endif
         if (at_done) begin
            m_act[k] = 1'b0;
            if (m_dm[k]) m_dmc[k]++;
            else         m_ifc[k]++;
         end else if (rst_n && !m_act[k]) begin
            if (if_req[k] && dm_req[k]) m_cfc[k]++;
            if (dm_req[k] || if_req[k]) begin
               m_act[k]   = 1'b1;
               m_g[k]     = cyc;
               m_dm[k]    = dm_req[k];
               m_we[k]    = dm_req[k] && dm_we[k];
               m_addr[k]  = dm_req[k] ? dm_addr[k] : if_addr[k];
               m_wdata[k] = dm_wdata[k];
               if (m_we[k]) begin
                  sh_mem[k][m_addr[k]] = m_wdata[k];
                  sh_wr[k][m_addr[k]]  = 1'b1;
               end
            end
         end
      end
   endtask

   // Raise a request now (just after an edge), measure cycles to done, check data, drop req on the done edge.
   task automatic do_req(input int k, input bit dm, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input int exp_lat,
                         input logic [DATA_W-1:0] exp_rd, input string name);
      int n;
      if (dm) begin
         dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = a; dm_wdata[k] = wd;
      end else begin
         if_req[k] = 1'b1; if_addr[k] = a;
      end
      for (n = 0; n < 40; n++) begin
         @(negedge clk); #1;
         if (dm ? dm_done[k] : if_done[k]) break;
         @(posedge clk); #1;
      end
      chk({name, "_lat"}, k, 64'(n), 64'(exp_lat));
      if (!(dm && we)) chk({name, "_rdata"}, k, 64'(dm ? dm_rdata[k] : if_rdata[k]), 64'(exp_rd));
      @(posedge clk); #1;
      if (dm) begin
         dm_req[k] = 1'b0; dm_we[k] = 1'b0;
      end else begin
         if_req[k] = 1'b0;
      end
   endtask

   initial begin
      int ndone;
      int first;
      rst_n = 1'b0;
      if_req = '0; dm_req = '0; dm_we = '0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 0, 64'(busy[0]), 64'd0);
      chk("rst_mem_en", 1, 64'(mem_en[1]), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RL=1 instance: fetch, store, load, then simultaneous requests
      do_req(0, 1'b0, 1'b0, 10'h004, 32'h0, 3, 32'h2002_0001, "fetch");
      do_req(0, 1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 2, 32'h0, "store");
      do_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0, 3, 32'hDEAD_BEEF, "load");
      fork
         do_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0, 3, 32'hDEAD_BEEF, "cf_dm");
         do_req(0, 1'b0, 1'b0, 10'h008, 32'h0, 7, 32'h2002_0002, "cf_if");
      join
`ifdef MEM_ARB_PERF_EN
      chk("perf_cf_lit", 0, 64'(perf_cf_cnt[0]), 64'd1);
`endif

      // RL=4 instance: back-to-back fetches, each 6 cycles from grant to done
      do_req(1, 1'b0, 1'b0, 10'h000, 32'h0, 6, 32'h2002_0000, "seq0");
      do_req(1, 1'b0, 1'b0, 10'h001, 32'h0, 6, 32'h2002_1000, "seq1");
      do_req(1, 1'b0, 1'b0, 10'h002, 32'h0, 6, 32'h2002_2000, "seq2");

      // Early drop of dm_req during WAIT: the load still completes exactly once
      dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 10'h3FF;
      repeat (3) @(posedge clk);
      #1 dm_req[1] = 1'b0;
      ndone = 0;
      first = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (dm_done[1]) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
      chk("drop_done_cnt", 1, 64'(ndone), 64'd1);
      chk("drop_done_at", 1, 64'(first), 64'd3);
      chk("drop_rdata", 1, 64'(dm_rdata[1]), 64'h2002_30FF);
      chk("drop_idle", 1, 64'(busy[1]), 64'd0);

      // Asynchronous reset in the middle of a load's WAIT
      @(posedge clk); #1;
      dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 10'h3FE;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", 1, 64'(busy[1]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 1, 64'(busy[1]), 64'd0);
      chk("rst_mid_done", 1, 64'(dm_done[1]), 64'd0);
      chk("rst_mid_dm_rdata", 1, 64'(dm_rdata[1]), 64'd0);
      chk("rst_mid_if_rdata", 1, 64'(if_rdata[1]), 64'd0);
      dm_req[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (dm_done[1]) ndone++;
      end
      chk("rst_no_done", 1, 64'(ndone), 64'd0);
      chk("rst_after_busy", 1, 64'(busy[1]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
